fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage directly upstream of the control/decoder FSM. Owns the program counter, issues instruction reads to the shared memory port, and holds the fetched word stable on `instr` while the decoder executes. Applies the decoder's PC controls (increment, branch displacement, register jump), captures `ir_reg` for loads, and steers the memory address to the load/store address when the decoder requests a data access.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `WAIT_LIMIT`, 15, FETCH cycles without `mem_ready` before `fetch_timeout` sets (1..255).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pc_en`  in  1  decoder: advance PC this cycle.
- `pc_mux_ctrl`  in  1  decoder: next PC = PC + `disp`.
- `pc_load`  in  1  decoder: next PC = `jump_target`.
- `disp`  in  16  signed branch displacement.
- `jump_target`  in  16  Rtarget value from register file.
- `ls_ctrl`  in  1  decoder: memory port used for load/store.
- `ls_addr`  in  16  load/store address from register file.
- `ir_en`  in  1  capture `instr` into `ir_reg`.
- `mem_rdata`  in  16  memory read data.
- `mem_ready`  in  1  `mem_rdata` valid this cycle.
- `mem_req`  out  1  instruction read request.
- `mem_addr`  out  16  memory address.
- `pc`  out  16  current PC.
- `instr`  out  16  held instruction word.
- `ir_reg`  out  16  instruction copy for multi-cycle loads.
- `instr_valid`  out  1  `instr` valid for current `pc`.
- `instr_count`  out  16  accepted `pc_en` count.
- `seq_err`  out  1  sticky: `pc_en` outside HOLD.
- `fetch_timeout`  out  1  sticky: memory wait exceeded `WAIT_LIMIT`.

## Operation
- States: BOOT, FETCH, HOLD.
- BOOT: `mem_req`=0, any `mem_ready` ignored (drains stale responses). Always -> FETCH next cycle.
- FETCH: `mem_req`=1, `mem_addr`=`pc`. On `mem_ready`: `instr` <= `mem_rdata`, -> HOLD. Otherwise stay; wait counter increments (saturating at 255). Counter reaching `WAIT_LIMIT` with no `mem_ready` sets `fetch_timeout`. Stay in FETCH regardless.
- HOLD: `instr_valid`=1, `mem_req`=0. On `pc_en`: PC updates, `instr_count`++ (wraps 0xFFFF->0), -> FETCH, wait counter cleared.
- Next-PC priority on accepted `pc_en`: `pc_load` -> `jump_target`; else `pc_mux_ctrl` -> `pc` + `disp`; else `pc` + 1. All arithmetic is 16-bit modulo 2^16 (0xFFFF+1 = 0x0000; `disp` two's complement).
- `pc_en` in BOOT or FETCH: ignored (PC, count, state unchanged), sets `seq_err`.
- `mem_addr` = `ls_addr` when `ls_ctrl`=1 and state=HOLD; else `pc`. `ls_ctrl` in BOOT/FETCH has no effect.
- `ir_en`=1 in HOLD: `ir_reg` <= `instr` at the clock edge. `ir_en` in other states is ignored.
- `instr` and `ir_reg` change only as stated above; `instr` stays stable throughout HOLD.

## Timing
- Reset (async, immediate): state=BOOT, `pc`=`RESET_PC`, `instr`=0, `ir_reg`=0, `instr_count`=0, `seq_err`=0, `fetch_timeout`=0, wait counter=0. Combinationally, `mem_req`=0, `instr_valid`=0, and `mem_addr`=`RESET_PC`.
- Reset asserted mid-FETCH aborts the fetch. The response is dropped by BOOT.
- After reset deasserts: the first edge enters FETCH. With 1-cycle memory (`mem_ready` in the second FETCH cycle), `instr_valid` rises 3 cycles after deassertion.
- `pc_en` accepted at edge N: `pc` is new and `mem_req`=1 in cycle N+1. With `mem_ready` in cycle N+k, `instr_valid` is high from cycle N+k+1.
- `instr_valid` drops in the cycle after `pc_en` is accepted. The decoder must not sample `instr` for the next instruction until `instr_valid`=1.
- `mem_ready` in the same cycle as `mem_req` first rises is accepted (zero-wait memory supported).
- `pc_en`, `ir_en`, `ls_ctrl` in one HOLD cycle are all honoured. `ir_reg` captures the old `instr`, and `mem_addr`=`ls_addr` for that cycle.

## Test plan
- Reset, then 1-cycle memory returning 0x1234, 0x5678, with a `pc_en` per HOLD -> `pc` 0,1,2; `instr` 0x1234 then 0x5678; `instr_count`=2; `mem_req` never high in BOOT.
- `pc`=5 in HOLD, `pc_en`+`pc_mux_ctrl`, `disp`=0xFFFE -> `pc`=3. Then `pc_en`+`pc_load`+`pc_mux_ctrl`, `jump_target`=0x0040 -> `pc`=0x0040 (load wins).
- Reach `pc`=0xFFFF, plain `pc_en` -> `pc`=0x0000. Set `instr_count`=0xFFFF, `pc_en` -> `instr_count`=0.
- `mem_ready` withheld 20 cycles with `WAIT_LIMIT`=15 -> `fetch_timeout` sets after 15 waiting cycles and stays set. `mem_ready` on cycle 21 -> HOLD with correct `instr`.
- `pc_en` pulsed during FETCH -> `seq_err`=1 and `pc` unchanged. In HOLD, `ls_ctrl`=1, `ls_addr`=0x0200, `ir_en`=1 -> `mem_addr`=0x0200 and `ir_reg`=`instr`.
- Reset asserted mid-FETCH with `mem_ready` arriving the cycle after deassert -> response ignored in BOOT, `pc`=`RESET_PC`, and a fresh fetch issues.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction reads and holds the
// fetched word on instr while the decoder works on it.
module fetch_unit #(
   parameter logic [15:0] RESET_PC   = 16'h0000,
   parameter int unsigned WAIT_LIMIT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_en,
   input  logic        pc_mux_ctrl,
   input  logic        pc_load,
   input  logic [15:0] disp,
   input  logic [15:0] jump_target,
   input  logic        ls_ctrl,
   input  logic [15:0] ls_addr,
   input  logic        ir_en,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [15:0] pc,
   output logic [15:0] instr,
   output logic [15:0] ir_reg,
   output logic        instr_valid,
   output logic [15:0] instr_count,
   output logic        seq_err,
   output logic        fetch_timeout
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] LP_WAIT_LIMIT = WAIT_LIMIT[7:0];

   state_t      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_instr;
   logic [15:0] r_ir;
   logic [15:0] r_instr_count;
   logic [7:0]  r_wait;
   logic        r_seq_err;
   logic        r_timeout;

   logic [15:0] w_next_pc;
   logic [7:0]  w_wait_inc;

   // Next-PC selection: register jump beats branch displacement beats increment.
   always_comb begin
      w_next_pc = r_pc + 16'd1;
      if (pc_load) begin
         w_next_pc = jump_target;
      end else if (pc_mux_ctrl) begin
         w_next_pc = r_pc + disp;
      end else begin
         w_next_pc = r_pc + 16'd1;
      end
   end

   // Memory wait counter saturates so a stuck memory never wraps it back below the limit.
   always_comb begin
      if (r_wait == 8'hFF) begin
         w_wait_inc = 8'hFF;
      end else begin
         w_wait_inc = r_wait + 8'd1;
      end
   end

   // Fetch FSM with PC, instruction hold, IR capture and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= BOOT;
         r_pc          <= RESET_PC;
         r_instr       <= 16'h0000;
         r_ir          <= 16'h0000;
         r_instr_count <= 16'h0000;
         r_wait        <= 8'd0;
         r_seq_err     <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               // Any response arriving here belongs to an aborted fetch and is dropped.
               if (pc_en) begin
                  r_seq_err <= 1'b1;
               end
               r_state <= FETCH;
            end
            FETCH: begin
               if (pc_en) begin
                  r_seq_err <= 1'b1;
               end
               if (mem_ready) begin
                  r_instr <= mem_rdata;
                  r_state <= HOLD;
               end else begin
                  r_wait <= w_wait_inc;
                  if (w_wait_inc >= LP_WAIT_LIMIT) begin
                     r_timeout <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (ir_en) begin
                  r_ir <= r_instr;
               end
               if (pc_en) begin
                  r_pc          <= w_next_pc;
                  r_instr_count <= r_instr_count + 16'd1;
                  r_wait        <= 8'd0;
                  r_state       <= FETCH;
               end
            end
            default: begin
               r_state <= BOOT;
            end
         endcase
      end
   end

   assign mem_req       = (r_state == FETCH);
   assign instr_valid   = (r_state == HOLD);
   assign mem_addr      = ((r_state == HOLD) && ls_ctrl) ? ls_addr : r_pc;
   assign pc            = r_pc;
   assign instr         = r_instr;
   assign ir_reg        = r_ir;
   assign instr_count   = r_instr_count;
   assign seq_err       = r_seq_err;
   assign fetch_timeout = r_timeout;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: hand-computed expectations per scenario.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic        pc_en;
   logic        pc_mux_ctrl;
   logic        pc_load;
   logic [15:0] disp;
   logic [15:0] jump_target;
   logic        ls_ctrl;
   logic [15:0] ls_addr;
   logic        ir_en;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] pc;
   logic [15:0] instr;
   logic [15:0] ir_reg;
   logic        instr_valid;
   logic [15:0] instr_count;
   logic        seq_err;
   logic        fetch_timeout;

   int vecs;
   int errs;

   fetch_unit #(.RESET_PC(16'h0000), .WAIT_LIMIT(15)) dut (
      .clk(clk), .reset(reset), .pc_en(pc_en), .pc_mux_ctrl(pc_mux_ctrl),
      .pc_load(pc_load), .disp(disp), .jump_target(jump_target),
      .ls_ctrl(ls_ctrl), .ls_addr(ls_addr), .ir_en(ir_en),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_req(mem_req),
      .mem_addr(mem_addr), .pc(pc), .instr(instr), .ir_reg(ir_reg),
      .instr_valid(instr_valid), .instr_count(instr_count),
      .seq_err(seq_err), .fetch_timeout(fetch_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; sampling and driving happen 2 time units after the edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // From a FETCH cycle: wait `dly` cycles, then return `data` with mem_ready.
   task automatic serve(input logic [15:0] data, input int dly);
      for (int i = 0; i < dly; i++) begin
         mem_ready = 1'b0;
         step();
      end
      mem_ready = 1'b1;
      mem_rdata = data;
      step();
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      vecs++;
      if (pc !== 16'h0000 || instr !== 16'h0000 || ir_reg !== 16'h0000 || instr_count !== 16'h0000) begin
         errs++;
         $display("FAIL reset_regs: pc=%h instr=%h ir=%h cnt=%h, required all 0000", pc, instr, ir_reg, instr_count);
      end
      vecs++;
      if (mem_req !== 1'b0 || instr_valid !== 1'b0 || seq_err !== 1'b0 || fetch_timeout !== 1'b0 || mem_addr !== 16'h0000) begin
         errs++;
         $display("FAIL reset_flags: req=%b valid=%b seq=%b to=%b addr=%h, required 0 0 0 0 0000",
                  mem_req, instr_valid, seq_err, fetch_timeout, mem_addr);
      end
   endtask

   task automatic test_sequential();
      reset = 1'b0;
      vecs++;
      if (mem_req !== 1'b0) begin
         errs++;
         $display("FAIL boot_req: mem_req=%b required 0", mem_req);
      end
      step();
      vecs++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
         errs++;
         $display("FAIL first_fetch: req=%b addr=%h valid=%b, required 1 0000 0", mem_req, mem_addr, instr_valid);
      end
      serve(16'h1234, 1);
      vecs++;
      if (instr_valid !== 1'b1 || instr !== 16'h1234 || pc !== 16'h0000 || mem_req !== 1'b0) begin
         errs++;
         $display("FAIL instr0: valid=%b instr=%h pc=%h req=%b, required 1 1234 0000 0", instr_valid, instr, pc, mem_req);
      end
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
      vecs++;
      if (pc !== 16'h0001 || instr_valid !== 1'b0 || mem_req !== 1'b1 || instr !== 16'h1234) begin
         errs++;
         $display("FAIL advance1: pc=%h valid=%b req=%b instr=%h, required 0001 0 1 1234", pc, instr_valid, mem_req, instr);
      end
      serve(16'h5678, 1);
      vecs++;
      if (instr !== 16'h5678 || pc !== 16'h0001 || instr_valid !== 1'b1) begin
         errs++;
         $display("FAIL instr1: instr=%h pc=%h valid=%b, required 5678 0001 1", instr, pc, instr_valid);
      end
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
      vecs++;
      if (pc !== 16'h0002 || instr_count !== 16'h0002) begin
         errs++;
         $display("FAIL advance2: pc=%h cnt=%h, required 0002 0002", pc, instr_count);
      end
      serve(16'h0000, 0);
   endtask

   task automatic test_branch();
      pc_en = 1'b1; pc_load = 1'b1; jump_target = 16'h0005;
      step();
      pc_en = 1'b0; pc_load = 1'b0;
      serve(16'h0A0A, 0);
      vecs++;
      if (pc !== 16'h0005) begin
         errs++;
         $display("FAIL jump5: pc=%h required 0005", pc);
      end
      pc_en = 1'b1; pc_mux_ctrl = 1'b1; disp = 16'hFFFE;
      step();
      pc_en = 1'b0; pc_mux_ctrl = 1'b0;
      vecs++;
      if (pc !== 16'h0003) begin
         errs++;
         $display("FAIL branch_neg: pc=%h required 0003", pc);
      end
      serve(16'h0B0B, 0);
      pc_en = 1'b1; pc_mux_ctrl = 1'b1; pc_load = 1'b1; jump_target = 16'h0040;
      step();
      pc_en = 1'b0; pc_mux_ctrl = 1'b0; pc_load = 1'b0;
      vecs++;
      if (pc !== 16'h0040) begin
         errs++;
         $display("FAIL load_priority: pc=%h required 0040", pc);
      end
      serve(16'h0C0C, 0);
   endtask

   task automatic test_wrap();
      pc_en = 1'b1; pc_load = 1'b1; jump_target = 16'hFFFF;
      step();
      pc_en = 1'b0; pc_load = 1'b0;
      serve(16'h0D0D, 0);
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
      vecs++;
      if (pc !== 16'h0000) begin
         errs++;
         $display("FAIL pc_wrap: pc=%h required 0000", pc);
      end
      serve(16'h0E0E, 0);
      dut.r_instr_count = 16'hFFFF;
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
      vecs++;
      if (instr_count !== 16'h0000 || pc !== 16'h0001) begin
         errs++;
         $display("FAIL count_wrap: cnt=%h pc=%h, required 0000 0001", instr_count, pc);
      end
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= 20; i++) begin
         mem_ready = 1'b0;
         step();
         if (i == 14) begin
            vecs++;
            if (fetch_timeout !== 1'b0) begin
               errs++;
               $display("FAIL timeout_early: to=%b after 14 waits, required 0", fetch_timeout);
            end
         end
         if (i == 15) begin
            vecs++;
            if (fetch_timeout !== 1'b1) begin
               errs++;
               $display("FAIL timeout_set: to=%b after 15 waits, required 1", fetch_timeout);
            end
         end
      end
      vecs++;
      if (fetch_timeout !== 1'b1 || mem_req !== 1'b1 || instr_valid !== 1'b0) begin
         errs++;
         $display("FAIL timeout_wait20: to=%b req=%b valid=%b, required 1 1 0", fetch_timeout, mem_req, instr_valid);
      end
      serve(16'hBEEF, 0);
      vecs++;
      if (instr !== 16'hBEEF || instr_valid !== 1'b1 || fetch_timeout !== 1'b1) begin
         errs++;
         $display("FAIL timeout_resume: instr=%h valid=%b to=%b, required BEEF 1 1", instr, instr_valid, fetch_timeout);
      end
   endtask

   task automatic test_seq_and_ls();
      pc_en = 1'b1;
      step();
      pc_en = 1'b1;
      mem_ready = 1'b0;
      ls_ctrl = 1'b1; ls_addr = 16'h0300; ir_en = 1'b1;
      #1;
      vecs++;
      if (mem_addr !== 16'h0002) begin
         errs++;
         $display("FAIL ls_in_fetch: mem_addr=%h required 0002", mem_addr);
      end
      step();
      pc_en = 1'b0; ls_ctrl = 1'b0; ir_en = 1'b0;
      vecs++;
      if (seq_err !== 1'b1 || pc !== 16'h0002 || instr_count !== 16'h0001 || mem_req !== 1'b1) begin
         errs++;
         $display("FAIL seq_err: seq=%b pc=%h cnt=%h req=%b, required 1 0002 0001 1", seq_err, pc, instr_count, mem_req);
      end
      vecs++;
      if (ir_reg !== 16'h0000) begin
         errs++;
         $display("FAIL ir_in_fetch: ir=%h required 0000", ir_reg);
      end
      serve(16'hA5A5, 0);
      ls_ctrl = 1'b1; ls_addr = 16'h0200; ir_en = 1'b1; pc_en = 1'b1;
      #1;
      vecs++;
      if (mem_addr !== 16'h0200) begin
         errs++;
         $display("FAIL ls_addr: mem_addr=%h required 0200", mem_addr);
      end
      step();
      ls_ctrl = 1'b0; ir_en = 1'b0; pc_en = 1'b0;
      vecs++;
      if (ir_reg !== 16'hA5A5 || pc !== 16'h0003 || mem_addr !== 16'h0003) begin
         errs++;
         $display("FAIL ir_capture: ir=%h pc=%h addr=%h, required A5A5 0003 0003", ir_reg, pc, mem_addr);
      end
      serve(16'h1111, 2);
      vecs++;
      if (ir_reg !== 16'hA5A5 || instr !== 16'h1111) begin
         errs++;
         $display("FAIL ir_hold: ir=%h instr=%h, required A5A5 1111", ir_reg, instr);
      end
      pc_en = 1'b1;
      step();
      pc_en = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      mem_ready = 1'b0;
      reset = 1'b1;
      #1;
      vecs++;
      if (pc !== 16'h0000 || mem_req !== 1'b0 || mem_addr !== 16'h0000 || seq_err !== 1'b0 ||
          fetch_timeout !== 1'b0 || instr !== 16'h0000 || ir_reg !== 16'h0000) begin
         errs++;
         $display("FAIL async_reset: pc=%h req=%b addr=%h seq=%b to=%b instr=%h ir=%h, required 0000 0 0000 0 0 0000 0000",
                  pc, mem_req, mem_addr, seq_err, fetch_timeout, instr, ir_reg);
      end
      step();
      reset = 1'b0;
      mem_ready = 1'b1; mem_rdata = 16'hDEAD;
      step();
      mem_ready = 1'b0;
      vecs++;
      if (instr !== 16'h0000 || instr_valid !== 1'b0 || mem_req !== 1'b1 || pc !== 16'h0000) begin
         errs++;
         $display("FAIL boot_drop: instr=%h valid=%b req=%b pc=%h, required 0000 0 1 0000", instr, instr_valid, mem_req, pc);
      end
      serve(16'h4321, 0);
      vecs++;
      if (instr !== 16'h4321 || instr_valid !== 1'b1) begin
         errs++;
         $display("FAIL refetch: instr=%h valid=%b, required 4321 1", instr, instr_valid);
      end
   endtask

   initial begin
      vecs = 0; errs = 0;
      reset = 1'b1; pc_en = 1'b0; pc_mux_ctrl = 1'b0; pc_load = 1'b0;
      disp = 16'h0000; jump_target = 16'h0000; ls_ctrl = 1'b0; ls_addr = 16'h0000;
      ir_en = 1'b0; mem_rdata = 16'h0000; mem_ready = 1'b0;
      test_reset();
      test_sequential();
      test_branch();
      test_wrap();
      test_timeout();
      test_seq_and_ls();
      test_reset_mid_fetch();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
